dec_digits_to_bin: RTL and testbench

//  Serial decimal-to-binary converter; the inverse of the hundreds/tens digit-extraction LUTs.

---
 rtl/dec_pkg.sv | 21 ++
 rtl/dec_digits_to_bin_mul10_add.sv | 16 +
 rtl/dec_digits_to_bin.sv | 116 +++++++++++
 tb/tb_dec_digits_to_bin.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the decimal-digit converters: FSM states, BCD limit,
// and a constant-width helper for digit counters.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Never returns less than 1 so a counter for a single-digit number still has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dec_digits_to_bin_mul10_add.sv
// Combinational acc*10 + d. The result is widened by 4 bits so it cannot wrap:
// (2^W-1)*10 + 9 < 2^(W+4).
module mul10_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       d,
    output logic [WIDTH+3:0] full
);

    logic [WIDTH+3:0] w_ext;

    assign w_ext = {4'b0000, acc};
    assign full  = (w_ext << 3) + (w_ext << 1) + {{WIDTH{1'b0}}, d};

endmodule

// File: rtl/dec_digits_to_bin.sv
// Serial BCD-to-binary converter, MS digit first, valid/ready on both sides.
// Build option DEC_SAT_EN: saturate out_value on overflow instead of wrapping.
module dec_digits_to_bin
    import dec_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic [3:0]       digit,
    input  logic             digit_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_ovf,
    output logic             out_err
);

    localparam int CW = clog2(MAX_DIGITS);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_err;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_value;
    logic             r_out_ovf;
    logic             r_out_err;

    logic             w_accept;
    logic             w_final;
    logic             w_bad;
    logic [3:0]       w_d;
    logic [WIDTH+3:0] w_full;
    logic             w_ovf_n;
    logic             w_err_n;
    logic [WIDTH-1:0] w_value;

    assign digit_ready = (r_state != OUT);
    assign w_accept    = digit_valid & digit_ready;
    assign w_bad       = (digit > BCD_MAX);
    assign w_d         = w_bad ? 4'd0 : digit;
    assign w_final     = digit_last | (r_cnt == CW'(MAX_DIGITS - 1));

    mul10_add #(.WIDTH(WIDTH)) u_mul10_add (
        .acc  (r_acc),
        .d    (w_d),
        .full (w_full)
    );

    // Overflow is sticky: once set, the truncated acc is only meaningful mod 2^WIDTH.
    assign w_ovf_n = r_ovf | (|w_full[WIDTH+3:WIDTH]);
    assign w_err_n = r_err | w_bad;

`ifdef DEC_SAT_EN
    assign w_value = w_ovf_n ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
    assign w_value = w_full[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_value <= '0;
            r_out_ovf   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACC: begin
                    if (w_accept) begin
                        r_acc <= w_full[WIDTH-1:0];
                        r_ovf <= w_ovf_n;
                        r_err <= w_err_n;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_final) begin
                            r_state     <= OUT;
                            r_out_valid <= 1'b1;
                            r_out_value <= w_value;
                            r_out_ovf   <= w_ovf_n;
                            r_out_err   <= w_err_n;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                OUT: begin
                    // Result registers stay put until the consumer takes them.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_value = r_out_value;
    assign out_ovf   = r_out_ovf;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_dec_digits_to_bin.sv
// Randomized scoreboard bench for dec_digits_to_bin with directed corner cases.
module tb_dec_digits_to_bin;

    localparam int W  = 8;
    localparam int MD = 3;

    typedef struct {
        logic [W-1:0] value;
        logic         ovf;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         digit_valid = 1'b0;
    logic         digit_ready;
    logic [3:0]   digit = 4'd0;
    logic         digit_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_value;
    logic         out_ovf;
    logic         out_err;

    int    errors = 0;
    int    checks = 0;
    exp_t  sb[$];
    int    cyc = 0;
    int    hold_until = 0;

    // Reference model: the decimal number in plain integer arithmetic.
    longint m_val = 0;
    int     m_cnt = 0;
    bit     m_err = 0;

    dec_digits_to_bin #(.WIDTH(W), .MAX_DIGITS(MD)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit       (digit),
        .digit_last  (digit_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_ovf     (out_ovf),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: decides out_ready for the coming edge and checks what gets consumed.
    bit           held = 0;
    logic [W-1:0] h_val;
    logic         h_ovf, h_err;
    exp_t         e;

    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            check("ready_vs_valid", digit_ready, !out_valid);
            if (held) begin
                check("held_valid", out_valid, 1);
                check("held_value", out_value, h_val);
                check("held_ovf", out_ovf, h_ovf);
                check("held_err", out_err, h_err);
            end
            held = 0;
            if (cyc < hold_until) out_ready = 1'b0;
            else                  out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_value", out_value, e.value);
                        check("out_ovf", out_ovf, e.ovf);
                        check("out_err", out_err, e.err);
                    end
                end else begin
                    held  = 1;
                    h_val = out_value;
                    h_ovf = out_ovf;
                    h_err = out_err;
                end
            end
        end
    end

    task automatic model_accept(input logic [3:0] d, input logic last);
        exp_t x;
        m_val = m_val * 10 + ((d > 9) ? 0 : d);
        m_err = m_err | (d > 9);
        m_cnt++;
        if (last || m_cnt == MD) begin
            x.ovf = (m_val > 255);
`ifdef DEC_SAT_EN
            x.value = x.ovf ? 8'hFF : W'(m_val % 256);
`else
            x.value = W'(m_val % 256);
`endif
            x.err = m_err;
            sb.push_back(x);
            m_val = 0;
            m_cnt = 0;
            m_err = 0;
        end
    endtask

    task automatic send_digit(input logic [3:0] d, input logic last);
        int  t;
        bit  done;
        bit  fin;
        t    = 0;
        done = 0;
        fin  = last || (m_cnt == MD - 1);
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = d;
        digit_last  = last;
        while (!done) begin
            if (digit_ready) begin
                @(posedge clk);
                done = 1;
                model_accept(d, last);
                #1;
                if (fin) check("latency_out_valid", out_valid, 1);
            end else begin
                t++;
                if (t > 200) begin
                    check("digit_accept_timeout", 0, 1);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        digit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int  nd;
        int  wait_cyc;
        logic [3:0] d;
        logic       l;

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_err", out_err, 0);
        check("rst_digit_ready", digit_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        send_digit(4'd2, 0); send_digit(4'd5, 0); send_digit(4'd5, 1);
        send_digit(4'd2, 0); send_digit(4'd5, 0); send_digit(4'd6, 1);
        send_digit(4'd1, 0); send_digit(4'hA, 0); send_digit(4'd3, 1);
        send_digit(4'd1, 0); send_digit(4'd2, 0); send_digit(4'd3, 0);
        send_digit(4'd0, 0); send_digit(4'd0, 0); send_digit(4'd7, 1);
        send_digit(4'd9, 0); send_digit(4'd9, 0); send_digit(4'd9, 1);

        // Consumer stalls while the next digit is already waiting.
        wait (sb.size() == 0);
        idle(2);
        hold_until = cyc + 8;
        send_digit(4'd7, 1);
        send_digit(4'd4, 1);

        // Reset in the middle of a number drops it without output.
        wait (sb.size() == 0);
        idle(2);
        send_digit(4'd9, 0);
        send_digit(4'd9, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_value", out_value, 0);
        check("midrst_out_ovf", out_ovf, 0);
        check("midrst_out_err", out_err, 0);
        check("midrst_digit_ready", digit_ready, 1);
        m_val = 0; m_cnt = 0; m_err = 0;
        @(negedge clk);
        rst = 1'b0;
        send_digit(4'd4, 1);

        for (int n = 0; n < 150; n++) begin
            nd = $urandom_range(1, 3);
            for (int i = 0; i < nd; i++) begin
                if ($urandom_range(0, 99) < 8) d = 4'($urandom_range(10, 15));
                else                           d = 4'($urandom_range(0, 9));
                l = (i == nd - 1) && !((nd == 3) && ($urandom_range(0, 1) == 1));
                send_digit(d, l);
                idle($urandom_range(0, 2));
            end
        end

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 1000) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("drain_timeout", sb.size(), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
